// File: rtl/nios2_cpu_debug_cmd_sync.sv
// ============================================================================
// Module   : nios2_cpu_debug_cmd_sync
// Brief    : Synchronises virtual-JTAG update strobes into clk, queues
//            {ir, sr} captures and decodes popped commands into action pulses.
// Revision : 1.0
// ============================================================================
`default_nettype none

module nios2_cpu_debug_cmd_sync #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int ACTION_BIT  = 34,
  parameter int FIFO_DEPTH  = 4,
  parameter int SYNC_STAGES = 2,
  localparam int NUM_CMD    = 2 ** IR_WIDTH,
  localparam int PTR_W      = $clog2(FIFO_DEPTH),
  localparam int CNT_W      = PTR_W + 1
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                vs_udr,
  input  logic                vs_uir,
  input  logic [IR_WIDTH-1:0] ir_in,
  input  logic [SR_WIDTH-1:0] sr,
  input  logic                cmd_ready,
  input  logic                ovf_clear,
  output logic                cmd_valid,
  output logic [IR_WIDTH-1:0] cmd_ir,
  output logic [CNT_W-1:0]    fifo_count,
  output logic [SR_WIDTH-1:0] jdo,
  output logic [NUM_CMD-1:0]  take_action,
  output logic [NUM_CMD-1:0]  take_no_action,
  output logic                ir_update,
  output logic                overflow
);

  localparam int                ENTRY_W    = IR_WIDTH + SR_WIDTH;
  localparam int                ARM_W      = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]  c_arm_done = ARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]  c_full_cnt = CNT_W'(FIFO_DEPTH);

  logic [SYNC_STAGES-1:0] r_udr_sync;
  logic [SYNC_STAGES-1:0] r_uir_sync;
  logic                   r_udr_prev;
  logic                   r_uir_prev;
  logic [ARM_W-1:0]       r_arm_cnt;

  logic [ENTRY_W-1:0]     r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]       r_wr_ptr;
  logic [PTR_W-1:0]       r_rd_ptr;
  logic [CNT_W-1:0]       r_count;

  logic                   w_armed;
  logic                   w_udr_rise;
  logic                   w_uir_rise;
  logic                   w_full;
  logic                   w_pop;
  logic                   w_push;
  logic                   w_drop;
  logic [ENTRY_W-1:0]     w_head;
  logic [IR_WIDTH-1:0]    w_head_ir;
  logic [SR_WIDTH-1:0]    w_head_sr;
  logic [NUM_CMD-1:0]     w_onehot;

  // Edges are masked until the chains have flushed post-reset levels, so a
  // strobe already high at release never looks like a fresh rise.
  assign w_armed    = (r_arm_cnt == c_arm_done);
  assign w_udr_rise = w_armed & r_udr_sync[SYNC_STAGES-1] & ~r_udr_prev;
  assign w_uir_rise = w_armed & r_uir_sync[SYNC_STAGES-1] & ~r_uir_prev;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_udr_sync <= '0;
      r_uir_sync <= '0;
      r_udr_prev <= 1'b0;
      r_uir_prev <= 1'b0;
      r_arm_cnt  <= '0;
    end else begin
      r_udr_sync <= {r_udr_sync[SYNC_STAGES-2:0], vs_udr};
      r_uir_sync <= {r_uir_sync[SYNC_STAGES-2:0], vs_uir};
      r_udr_prev <= r_udr_sync[SYNC_STAGES-1];
      r_uir_prev <= r_uir_sync[SYNC_STAGES-1];
      if (!w_armed) begin
        r_arm_cnt <= r_arm_cnt + 1'b1;
      end
    end
  end

  assign w_full     = (r_count == c_full_cnt);
  assign cmd_valid  = (r_count != '0);
  assign fifo_count = r_count;
  assign w_pop      = cmd_valid & cmd_ready;
  // When full, a simultaneous pop frees the head slot that wr_ptr points at.
  assign w_push     = w_udr_rise & (~w_full | w_pop);
  assign w_drop     = w_udr_rise & w_full & ~w_pop;

  assign w_head    = r_mem[r_rd_ptr];
  assign w_head_ir = w_head[ENTRY_W-1:SR_WIDTH];
  assign w_head_sr = w_head[SR_WIDTH-1:0];
  assign cmd_ir    = cmd_valid ? w_head_ir : '0;
  assign w_onehot  = NUM_CMD'(1) << w_head_ir;

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {ir_in, sr};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
      overflow       <= 1'b0;
    end else begin
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= w_uir_rise;
      if (w_pop) begin
        jdo <= w_head_sr;
        if (w_head_sr[ACTION_BIT]) begin
          take_action <= w_onehot;
        end else begin
          take_no_action <= w_onehot;
        end
      end
      if (ovf_clear) begin
        overflow <= 1'b0;
      end else if (w_drop) begin
        overflow <= 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_nios2_cpu_debug_cmd_sync.sv
// ============================================================================
// Module   : tb_nios2_cpu_debug_cmd_sync
// Brief    : Directed and randomized bench against a queue-based command model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_nios2_cpu_debug_cmd_sync;

  localparam int S     = 2;
  localparam int DEPTH = 4;
  localparam int SRW   = 38;
  localparam int IRW   = 2;
  localparam int AB    = 34;
  localparam int NCMD  = 2 ** IRW;
  localparam int CNTW  = $clog2(DEPTH) + 1;

  logic            clk = 1'b0;
  logic            reset_n = 1'b1;
  logic            vs_udr = 1'b0;
  logic            vs_uir = 1'b0;
  logic [IRW-1:0]  ir_in = '0;
  logic [SRW-1:0]  sr = '0;
  logic            cmd_ready = 1'b0;
  logic            ovf_clear = 1'b0;
  logic            cmd_valid;
  logic [IRW-1:0]  cmd_ir;
  logic [CNTW-1:0] fifo_count;
  logic [SRW-1:0]  jdo;
  logic [NCMD-1:0] take_action;
  logic [NCMD-1:0] take_no_action;
  logic            ir_update;
  logic            overflow;

  nios2_cpu_debug_cmd_sync #(
    .SR_WIDTH(SRW), .IR_WIDTH(IRW), .ACTION_BIT(AB),
    .FIFO_DEPTH(DEPTH), .SYNC_STAGES(S)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready), .ovf_clear(ovf_clear),
    .cmd_valid(cmd_valid), .cmd_ir(cmd_ir), .fifo_count(fifo_count),
    .jdo(jdo), .take_action(take_action), .take_no_action(take_no_action),
    .ir_update(ir_update), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: levels seen at each clk edge since release, plus a queue.
  bit                 udr_lv [0:16383];
  bit                 uir_lv [0:16383];
  int                 n;
  logic [IRW+SRW-1:0] mq [$];
  logic [SRW-1:0]     exp_jdo;
  logic [NCMD-1:0]    exp_ta;
  logic [NCMD-1:0]    exp_tna;
  bit                 exp_iru;
  bit                 exp_ovf;
  bit                 cur_udr;
  bit                 cur_uir;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit udr_at(input int i);
    return (i < 1) ? 1'b0 : udr_lv[i];
  endfunction

  function automatic bit uir_at(input int i);
    return (i < 1) ? 1'b0 : uir_lv[i];
  endfunction

  task automatic compare_all();
    logic [IRW-1:0] e_ir;
    e_ir = (mq.size() != 0) ? mq[0][SRW+:IRW] : '0;
    chk("cmd_valid", cmd_valid, mq.size() != 0);
    chk("fifo_count", fifo_count, mq.size());
    chk("cmd_ir", cmd_ir, e_ir);
    chk("jdo", jdo, exp_jdo);
    chk("take_action", take_action, exp_ta);
    chk("take_no_action", take_no_action, exp_tna);
    chk("ir_update", ir_update, exp_iru);
    chk("overflow", overflow, exp_ovf);
  endtask

  // One clk cycle: drive inputs, predict the post-edge state, check it.
  task automatic step(input bit udr, input bit uir, input logic [IRW-1:0] ir,
                      input logic [SRW-1:0] s, input bit rdy, input bit clr);
    bit                 armed, rise_u, rise_i, pop;
    int                 sz;
    logic [IRW+SRW-1:0] h;
    vs_udr = udr; vs_uir = uir; ir_in = ir; sr = s;
    cmd_ready = rdy; ovf_clear = clr;
    cur_udr = udr; cur_uir = uir;
    if (n < 16383) n++;
    udr_lv[n] = udr;
    uir_lv[n] = uir;
    armed  = (n - 1) >= S + 1;
    rise_u = armed && udr_at(n - S) && !udr_at(n - S - 1);
    rise_i = armed && uir_at(n - S) && !uir_at(n - S - 1);
    sz  = mq.size();
    pop = (sz != 0) && rdy;
    exp_ta  = '0;
    exp_tna = '0;
    exp_iru = rise_i;
    if (pop) begin
      h = mq.pop_front();
      exp_jdo = h[SRW-1:0];
      if (h[AB]) exp_ta[h[SRW+:IRW]] = 1'b1;
      else       exp_tna[h[SRW+:IRW]] = 1'b1;
    end
    if (rise_u) begin
      if (sz < DEPTH || pop) mq.push_back({ir, s});
      else if (!clr)         exp_ovf = 1'b1;
    end
    if (clr) exp_ovf = 1'b0;
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset(input bit udr_hold, input int cycles);
    reset_n = 1'b0;
    vs_udr = udr_hold; vs_uir = 1'b0; cmd_ready = 1'b0; ovf_clear = 1'b0;
    cur_udr = udr_hold; cur_uir = 1'b0;
    #1;
    mq.delete();
    exp_jdo = '0; exp_ta = '0; exp_tna = '0; exp_iru = 1'b0; exp_ovf = 1'b0;
    n = 0;
    compare_all();
    repeat (cycles) @(negedge clk);
    compare_all();
    reset_n = 1'b1;
  endtask

  task automatic strobe(input logic [IRW-1:0] ir, input logic [SRW-1:0] s, input bit rdy);
    step(1'b1, 1'b0, ir, s, rdy, 1'b0);
    step(1'b0, 1'b0, ir, s, rdy, 1'b0);
  endtask

  logic [SRW-1:0] s_act;
  logic [SRW-1:0] s_noact;
  logic [63:0]    rnd;
  bit             rdy_mode;

  initial begin
    #2;
    // Level high across release must not produce a push.
    do_reset(1'b1, 3);
    repeat (10) step(1'b1, 1'b0, 2'd3, 38'h11, 1'b0, 1'b0);
    chk("held_level_count", fifo_count, 0);
    repeat (3) step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);

    s_act = '0; s_act[AB] = 1'b1; s_act[15:0] = 16'h1234;
    step(1'b1, 1'b0, 2'd2, s_act, 1'b1, 1'b0);
    repeat (5) step(1'b1, 1'b0, 2'd2, s_act, 1'b1, 1'b0);
    chk("jdo_lo_held", jdo[15:0], 16'h1234);
    step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);

    s_noact = 38'h00_0000_5678;
    repeat (5) step(1'b1, 1'b0, 2'd1, s_noact, 1'b1, 1'b0);
    repeat (2) step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("jdo_noact", jdo, s_noact);

    // Five strobes into a four-deep queue with nobody popping.
    for (int i = 0; i < 5; i++) strobe(IRW'(i), SRW'(i + 1) | (SRW'(i & 1) << AB), 1'b0);
    repeat (S + 1) step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    chk("full_count", fifo_count, DEPTH);
    chk("ovf_set", overflow, 1);
    repeat (5) step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("drained", fifo_count, 0);
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b1);
    chk("ovf_cleared", overflow, 0);

    // Full queue: the push edge lands exactly on a pop.
    for (int i = 0; i < 4; i++) strobe(IRW'(i), SRW'(16 + i), 1'b0);
    repeat (S + 1) step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    repeat (S) step(1'b1, 1'b0, 2'd3, 38'h2A_BCDE_F012, 1'b0, 1'b0);
    step(1'b1, 1'b0, 2'd3, 38'h2A_BCDE_F012, 1'b1, 1'b0);
    step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    chk("full_pushpop_count", fifo_count, DEPTH);
    chk("full_pushpop_ovf", overflow, 0);
    repeat (4) step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);
    chk("last_popped_new", jdo, 38'h2A_BCDE_F012);

    // Simultaneous udr and uir rise.
    step(1'b1, 1'b1, 2'd2, s_act, 1'b0, 1'b0);
    repeat (S + 2) step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    chk("dual_edge_count", fifo_count, 1);
    repeat (2) step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);

    // Reset with three entries queued.
    for (int i = 0; i < 3; i++) strobe(IRW'(i), SRW'(40 + i), 1'b0);
    repeat (S + 1) step(1'b0, 1'b0, 2'd0, '0, 1'b0, 1'b0);
    chk("pre_reset_count", fifo_count, 3);
    do_reset(1'b0, 2);
    repeat (3) step(1'b0, 1'b0, 2'd0, '0, 1'b1, 1'b0);

    // Randomized traffic with bursty ready and occasional clears/resets.
    rdy_mode = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      bit u, v, r, cl;
      if ($urandom_range(0, 49) == 0) rdy_mode = ~rdy_mode;
      u  = ($urandom_range(0, 2) == 0) ? ~cur_udr : cur_udr;
      v  = ($urandom_range(0, 5) == 0) ? ~cur_uir : cur_uir;
      r  = rdy_mode ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
      cl = ($urandom_range(0, 39) == 0);
      rnd = {$urandom, $urandom};
      if ($urandom_range(0, 599) == 0) begin
        do_reset(1'($urandom_range(0, 1)), 2);
      end else begin
        step(u, v, rnd[63:62], rnd[SRW-1:0], r, cl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
